// File: rtl/instruction_sequencer_if.sv
// Program-memory fetch bus between the instruction sequencer and memory.
// The master raises mem_req with mem_addr and holds both until mem_ack.
// The memory returns mem_rdata in the same cycle as mem_ack.
interface instruction_sequencer_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) ();
  logic                   mem_req;
  logic [PC_WIDTH-1:0]    mem_addr;
  logic                   mem_ack;
  logic [INSTR_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches each instruction over the memory bus,
// holds it for the control unit, walks the 2-bit step counter and retires
// on clear_counter, with a watchdog that forces retirement if step 11 stalls.
//
// state | meaning
// IDLE  | stopped, step 00, no request; leaves when run is sampled high
// FETCH | mem_req held with mem_addr = pc until mem_ack delivers the word
// EXEC  | instruction valid, step 00->01->10->11, retire on clear or watchdog
module instruction_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int WDOG_CYCLES = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  instruction_sequencer_if.master mem,
  input  logic                    clear_counter,
  output logic [INSTR_WIDTH-1:0]  instruction,
  output logic [1:0]              current_state,
  output logic                    instr_valid,
  output logic [PC_WIDTH-1:0]     pc,
  output logic                    retire,
  output logic                    seq_error
);

  // Watchdog is a down-counter loaded on entry to step 11; terminal count 0
  // on a cycle without clear_counter is the WDOG_CYCLES-th stalled cycle.
  localparam int                WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic [WDOG_W-1:0]      wdog_q, wdog_d;
  logic [PC_WIDTH-1:0]    pc_d;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic [1:0]             step_d;
  logic                   valid_d;
  logic                   retire_d;
  logic                   err_d;
  logic                   do_retire;

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = pc;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    wdog_d    = wdog_q;
    pc_d      = pc;
    instr_d   = instruction;
    step_d    = current_state;
    valid_d   = instr_valid;
    retire_d  = 1'b0;
    err_d     = seq_error;
    do_retire = 1'b0;

    unique case (state_q)
      IDLE: begin
        step_d    = 2'b00;
        valid_d   = 1'b0;
        mem_req_d = 1'b0;
        if (run) begin
          state_d   = FETCH;
          mem_req_d = 1'b1;
        end
      end

      FETCH: begin
        mem_req_d = 1'b1;
        if (mem_req_q && mem.mem_ack) begin
          instr_d   = mem.mem_rdata;
          step_d    = 2'b00;
          valid_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = EXEC;
        end
      end

      EXEC: begin
        if (current_state != 2'b11) begin
          step_d = current_state + 2'b01;
          if (current_state == 2'b10) begin
            wdog_d = WDOG_LOAD;
          end
        end else if (clear_counter) begin
          do_retire = 1'b1;
        end else if (wdog_q == '0) begin
          do_retire = 1'b1;
          err_d     = 1'b1;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end

        // run is only consulted here, so dropping it mid-instruction
        // still lets the current instruction finish.
        if (do_retire) begin
          pc_d      = pc + 1'b1;
          retire_d  = 1'b1;
          step_d    = 2'b00;
          wdog_d    = '0;
          valid_d   = 1'b0;
          mem_req_d = run;
          state_d   = run ? FETCH : IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        valid_d   = 1'b0;
        step_d    = 2'b00;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      wdog_q        <= '0;
      pc            <= '0;
      instruction   <= '0;
      current_state <= 2'b00;
      instr_valid   <= 1'b0;
      retire        <= 1'b0;
      seq_error     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      wdog_q        <= wdog_d;
      pc            <= pc_d;
      instruction   <= instr_d;
      current_state <= step_d;
      instr_valid   <= valid_d;
      retire        <= retire_d;
      seq_error     <= err_d;
    end
  end

endmodule
